// File: rtl/axi_id_remap_if.sv
// AXI address/data/response channel bundle shared by the wide-ID upstream
// side and the compacted-ID downstream side of the ID remapper.
interface axi_channel #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_id_remap.sv
// Compacts wide AXI master IDs onto a small slot index per direction and
// restores the original ID on the response path.

// One direction's slot table: lookup for new requests, reverse map for responses.
module axi_id_remap_table #(
    parameter int SLOT_NUM = 4,
    parameter int CNT_W    = 4,
    parameter int ID_W     = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ID_W-1:0]             req_id,
    input  logic                        req_hs,
    output logic                        slot_found,
    output logic [$clog2(SLOT_NUM)-1:0] slot_idx,
    input  logic                        rsp_hs,
    input  logic [$clog2(SLOT_NUM)-1:0] rsp_idx,
    output logic [ID_W-1:0]             rsp_id
);
    localparam int IDX_W = $clog2(SLOT_NUM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SLOT_NUM-1:0] valid_vec;
    logic [ID_W-1:0]     id_arr  [SLOT_NUM];
    logic [CNT_W-1:0]    cnt_arr [SLOT_NUM];

    logic             match_any;
    logic             match_sat;
    logic             free_any;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;

    // Descending scan so the lowest free index wins; at most one entry can hold a given ID.
    always_comb begin
        match_any = 1'b0;
        match_sat = 1'b0;
        free_any  = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        for (int i = SLOT_NUM - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (valid_vec[i] && id_arr[i] == req_id) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
                match_sat = (cnt_arr[i] == CNT_MAX);
            end
        end
        slot_found = match_any ? !match_sat : free_any;
        slot_idx   = match_any ? match_idx : free_idx;
    end

    assign rsp_id = id_arr[rsp_idx];

    generate
        for (genvar gi = 0; gi < SLOT_NUM; gi++) begin : g_slot
            logic             valid_reg;
            logic [ID_W-1:0]  id_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             inc;
            logic             dec;

            assign inc = req_hs && (slot_idx == IDX_W'(gi));
            // A response against an unused slot is ignored so the count cannot underflow.
            assign dec = rsp_hs && (rsp_idx == IDX_W'(gi)) && valid_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    valid_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else if (inc && !dec) begin
                    valid_reg <= 1'b1;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                end else if (dec && !inc) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        valid_reg <= 1'b0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (inc) begin
                    id_reg <= req_id;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign id_arr[gi]    = id_reg;
            assign cnt_arr[gi]   = cnt_reg;
        end
    endgenerate

    a_rsp_slot_valid: assert property (@(posedge clk) disable iff (!rstn)
        rsp_hs |-> valid_vec[rsp_idx]);
endmodule

module axi_id_remap #(
    parameter int SLOT_NUM         = 4,
    parameter int ACTIVE_CNT_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    axi_channel.slave  master,
    axi_channel.master slave
);
    localparam int IDX_W   = $clog2(SLOT_NUM);
    localparam int MID_W   = master.ID_WIDTH;
    localparam int SID_W   = slave.ID_WIDTH;
    localparam int M_ADDRW = master.ADDR_WIDTH;
    localparam int S_ADDRW = slave.ADDR_WIDTH;
    localparam int M_DATAW = master.DATA_WIDTH;
    localparam int S_DATAW = slave.DATA_WIDTH;

    generate
        if (M_ADDRW != S_ADDRW || M_DATAW != S_DATAW) begin : g_bus_width_err
            $error("axi_id_remap: ADDR_WIDTH/DATA_WIDTH differ between channels");
        end
        if (SID_W != IDX_W) begin : g_id_width_err
            $error("axi_id_remap: slave ID_WIDTH must equal clog2(SLOT_NUM)");
        end
        if (SLOT_NUM < 2 || SLOT_NUM > 16 || (SLOT_NUM & (SLOT_NUM - 1)) != 0) begin : g_slot_err
            $error("axi_id_remap: SLOT_NUM must be a power of two in 2..16");
        end
    endgenerate

    logic             aw_found;
    logic [IDX_W-1:0] aw_slot;
    logic             aw_hs;
    logic             b_hs;
    logic             ar_found;
    logic [IDX_W-1:0] ar_slot;
    logic             ar_hs;
    logic             r_last_hs;

    // Selection depends only on registered table state, so no response-to-valid path exists.
    assign slave.awvalid  = master.awvalid & aw_found & rstn;
    assign master.awready = slave.awready & aw_found & rstn;
    assign slave.awid     = aw_slot;
    assign slave.awaddr   = master.awaddr;
    assign slave.awlen    = master.awlen;
    assign slave.awsize   = master.awsize;
    assign slave.awburst  = master.awburst;
    assign aw_hs          = slave.awvalid & slave.awready;

    assign slave.wdata   = master.wdata;
    assign slave.wstrb   = master.wstrb;
    assign slave.wlast   = master.wlast;
    assign slave.wvalid  = master.wvalid;
    assign master.wready = slave.wready;

    assign master.bresp  = slave.bresp;
    assign master.bvalid = slave.bvalid;
    assign slave.bready  = master.bready;
    assign b_hs          = slave.bvalid & master.bready;

    assign slave.arvalid  = master.arvalid & ar_found & rstn;
    assign master.arready = slave.arready & ar_found & rstn;
    assign slave.arid     = ar_slot;
    assign slave.araddr   = master.araddr;
    assign slave.arlen    = master.arlen;
    assign slave.arsize   = master.arsize;
    assign slave.arburst  = master.arburst;
    assign ar_hs          = slave.arvalid & slave.arready;

    assign master.rdata  = slave.rdata;
    assign master.rresp  = slave.rresp;
    assign master.rlast  = slave.rlast;
    assign master.rvalid = slave.rvalid;
    assign slave.rready  = master.rready;
    // A read slot stays busy until the final beat of its burst.
    assign r_last_hs     = slave.rvalid & master.rready & slave.rlast;

    axi_id_remap_table #(
        .SLOT_NUM (SLOT_NUM),
        .CNT_W    (ACTIVE_CNT_WIDTH),
        .ID_W     (MID_W)
    ) u_wr_table (
        .clk        (clk),
        .rstn       (rstn),
        .req_id     (master.awid),
        .req_hs     (aw_hs),
        .slot_found (aw_found),
        .slot_idx   (aw_slot),
        .rsp_hs     (b_hs),
        .rsp_idx    (slave.bid),
        .rsp_id     (master.bid)
    );

    axi_id_remap_table #(
        .SLOT_NUM (SLOT_NUM),
        .CNT_W    (ACTIVE_CNT_WIDTH),
        .ID_W     (MID_W)
    ) u_rd_table (
        .clk        (clk),
        .rstn       (rstn),
        .req_id     (master.arid),
        .req_hs     (ar_hs),
        .slot_found (ar_found),
        .slot_idx   (ar_slot),
        .rsp_hs     (r_last_hs),
        .rsp_idx    (slave.rid),
        .rsp_id     (master.rid)
    );
endmodule

// File: tb/tb_axi_id_remap.sv
// Randomised and directed bench for axi_id_remap against an outstanding-count
// reference model (4 slots, 2-bit counters so saturation is reachable).
module tb_axi_id_remap;
    localparam int SLOTS   = 4;
    localparam int MAX_OUT = 3;

    logic clk;
    logic rstn;

    axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
    axi_channel #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    axi_id_remap #(
        .SLOT_NUM         (SLOTS),
        .ACTIVE_CNT_WIDTH (2)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .master (m_if.slave),
        .slave  (s_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per slot, how many transactions are outstanding and for which master ID.
    int         w_cnt [SLOTS];
    logic [7:0] w_oid [SLOTS];
    int         r_cnt [SLOTS];
    logic [7:0] r_oid [SLOTS];

    bit s_awready = 1'b1;
    bit s_arready = 1'b1;
    bit m_bready  = 1'b1;
    bit m_rready  = 1'b1;

    bit         obs_aw_ok;
    int         obs_aw_slot;
    bit         obs_ar_ok;
    int         obs_ar_slot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slot an ID would be granted: reuse its slot unless full, else lowest idle slot, else -1.
    function automatic int pick(input bit rd, input logic [7:0] id);
        for (int i = 0; i < SLOTS; i++) begin
            int c;
            logic [7:0] o;
            c = rd ? r_cnt[i] : w_cnt[i];
            o = rd ? r_oid[i] : w_oid[i];
            if (c > 0 && o == id) return (c < MAX_OUT) ? i : -1;
        end
        for (int i = 0; i < SLOTS; i++) begin
            if ((rd ? r_cnt[i] : w_cnt[i]) == 0) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SLOTS; i++) begin
            w_cnt[i] = 0;
            r_cnt[i] = 0;
        end
    endtask

    task automatic cycle(input bit awv, input logic [7:0] awid, input bit bv, input int bs,
                         input bit arv, input logic [7:0] arid, input bit rv, input int rs,
                         input bit rl);
        int          ew;
        int          er;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  len;
        bit          wv;
        bit          wr;
        @(negedge clk);
        addr = $urandom;
        data = $urandom;
        len  = 8'($urandom);
        wv   = 1'($urandom);
        wr   = 1'($urandom);
        m_if.awvalid = awv;  m_if.awid = awid; m_if.awaddr = addr; m_if.awlen = len;
        s_if.awready = s_awready;
        m_if.wdata   = ~data; m_if.wvalid = wv; s_if.wready = wr;
        s_if.bvalid  = bv;   s_if.bid = 2'(bs); s_if.bresp = 2'(data[1:0]);
        m_if.bready  = m_bready;
        m_if.arvalid = arv;  m_if.arid = arid; m_if.araddr = ~addr;
        s_if.arready = s_arready;
        s_if.rvalid  = rv;   s_if.rid = 2'(rs); s_if.rlast = rl; s_if.rdata = data;
        m_if.rready  = m_rready;
        #1;
        ew = pick(1'b0, awid);
        er = pick(1'b1, arid);
        check("awvalid", 32'(s_if.awvalid), 32'(awv && ew >= 0));
        check("awready", 32'(m_if.awready), 32'(s_awready && ew >= 0));
        if (awv && ew >= 0) begin
            check("awid", 32'(s_if.awid), 32'(ew));
            check("awaddr", s_if.awaddr, addr);
            check("awlen", 32'(s_if.awlen), 32'(len));
        end
        check("wdata", s_if.wdata, ~data);
        check("wvalid", 32'(s_if.wvalid), 32'(wv));
        check("wready", 32'(m_if.wready), 32'(wr));
        check("bvalid", 32'(m_if.bvalid), 32'(bv));
        if (bv) check("bid", 32'(m_if.bid), 32'(w_oid[bs]));
        check("arvalid", 32'(s_if.arvalid), 32'(arv && er >= 0));
        check("arready", 32'(m_if.arready), 32'(s_arready && er >= 0));
        if (arv && er >= 0) begin
            check("arid", 32'(s_if.arid), 32'(er));
            check("araddr", s_if.araddr, ~addr);
        end
        if (rv) begin
            check("rid", 32'(m_if.rid), 32'(r_oid[rs]));
            check("rdata", m_if.rdata, data);
            check("rlast", 32'(m_if.rlast), 32'(rl));
        end
        obs_aw_ok   = awv && s_awready && (m_if.awready === 1'b1);
        obs_aw_slot = int'(s_if.awid);
        obs_ar_ok   = arv && s_arready && (m_if.arready === 1'b1);
        obs_ar_slot = int'(s_if.arid);
        @(posedge clk);
        // Model updates use the pre-edge state computed above.
        if (awv && s_awready && ew >= 0) begin
            w_cnt[ew]++;
            w_oid[ew] = awid;
            $display("AW id=0x%02h -> slot %0d (outstanding %0d)", awid, ew, w_cnt[ew]);
        end
        if (bv && m_bready) begin
            w_cnt[bs]--;
            $display("B  slot %0d -> id=0x%02h (outstanding %0d)", bs, w_oid[bs], w_cnt[bs]);
        end
        if (arv && s_arready && er >= 0) begin
            r_cnt[er]++;
            r_oid[er] = arid;
            $display("AR id=0x%02h -> slot %0d (outstanding %0d)", arid, er, r_cnt[er]);
        end
        if (rv && m_rready) begin
            if (rl) r_cnt[rs]--;
            $display("R  slot %0d last=%0d -> id=0x%02h (outstanding %0d)", rs, rl, r_oid[rs], r_cnt[rs]);
        end
    endtask

    task automatic idle();
        cycle(0, 8'h0, 0, 0, 0, 8'h0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            int bs;
            int rs;
            bs = -1;
            rs = -1;
            for (int i = SLOTS - 1; i >= 0; i--) begin
                if (w_cnt[i] > 0) bs = i;
                if (r_cnt[i] > 0) rs = i;
            end
            if (bs < 0 && rs < 0) break;
            cycle(0, 8'h0, bs >= 0, (bs >= 0) ? bs : 0, 0, 8'h0, rs >= 0, (rs >= 0) ? rs : 0, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        rstn = 1'b0;
        m_if.awvalid = 0; m_if.awid = 0; m_if.awaddr = 0; m_if.awlen = 0;
        m_if.awsize = 3'd2; m_if.awburst = 2'd1;
        m_if.wdata = 0; m_if.wstrb = 4'hF; m_if.wlast = 1; m_if.wvalid = 0;
        m_if.bready = 1;
        m_if.arvalid = 0; m_if.arid = 0; m_if.araddr = 0; m_if.arlen = 0;
        m_if.arsize = 3'd2; m_if.arburst = 2'd1;
        m_if.rready = 1;
        s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 0; s_if.bid = 0; s_if.bresp = 0;
        s_if.arready = 1; s_if.rvalid = 0; s_if.rid = 0; s_if.rdata = 0; s_if.rresp = 0;
        s_if.rlast = 0;

        // Reset: request present, nothing may be granted.
        repeat (2) @(negedge clk);
        m_if.awvalid = 1; m_if.awid = 8'h2A; m_if.arvalid = 1; m_if.arid = 8'h2B;
        #1;
        check("rst_awready", 32'(m_if.awready), 32'd0);
        check("rst_awvalid", 32'(s_if.awvalid), 32'd0);
        check("rst_arready", 32'(m_if.arready), 32'd0);
        check("rst_arvalid", 32'(s_if.arvalid), 32'd0);
        @(negedge clk);
        m_if.awvalid = 0; m_if.arvalid = 0;
        rstn = 1'b1;

        // Single write, then slot reuse after B.
        cycle(1, 8'h2A, 0, 0, 0, 8'h0, 0, 0, 0);
        check("w1_accept", 32'(obs_aw_ok), 32'd1);
        check("w1_slot", 32'(obs_aw_slot), 32'd0);
        cycle(0, 8'h0, 1, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h11, 0, 0, 0, 8'h0, 0, 0, 0);
        check("w1_reuse_slot", 32'(obs_aw_slot), 32'd0);
        drain();

        // Same-ID reuse on read; count only drops on the last beat.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 8'h0, 0, 0, 1, 8'h05, 0, 0, 0);
            check("reuse_arid", 32'(obs_ar_slot), 32'd0);
        end
        cycle(0, 8'h0, 0, 0, 0, 8'h0, 1, 0, 0);
        cycle(0, 8'h0, 0, 0, 1, 8'h05, 0, 0, 0);
        check("reuse_sat_after_nonlast", 32'(obs_ar_ok), 32'd0);
        cycle(0, 8'h0, 0, 0, 0, 8'h0, 1, 0, 1);
        cycle(0, 8'h0, 0, 0, 1, 8'h05, 0, 0, 0);
        check("reuse_after_last", 32'(obs_ar_ok), 32'd1);
        drain();

        // Read table full; freed slot goes to the waiting ID one cycle later.
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 8'h0, 0, 0, 1, 8'(k), 0, 0, 0);
            check("full_fill_slot", 32'(obs_ar_slot), 32'(k - 1));
        end
        cycle(0, 8'h0, 0, 0, 1, 8'h05, 0, 0, 0);
        check("full_stall", 32'(obs_ar_ok), 32'd0);
        cycle(0, 8'h0, 0, 0, 1, 8'h05, 1, 2, 1);
        check("full_stall_same_edge", 32'(obs_ar_ok), 32'd0);
        cycle(0, 8'h0, 0, 0, 1, 8'h05, 0, 0, 0);
        check("full_take_freed", 32'(obs_ar_ok), 32'd1);
        check("full_freed_slot", 32'(obs_ar_slot), 32'd2);
        drain();

        // Write counter saturation stalls the ID even though slots are free.
        for (int k = 0; k < 3; k++) cycle(1, 8'h07, 0, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h07, 0, 0, 0, 8'h0, 0, 0, 0);
        check("sat_stall", 32'(obs_aw_ok), 32'd0);
        cycle(1, 8'h07, 1, 0, 0, 8'h0, 0, 0, 0);
        check("sat_stall_same_edge", 32'(obs_aw_ok), 32'd0);
        cycle(1, 8'h07, 0, 0, 0, 8'h0, 0, 0, 0);
        check("sat_resume", 32'(obs_aw_ok), 32'd1);
        check("sat_resume_slot", 32'(obs_aw_slot), 32'd0);
        drain();

        // Increment and decrement on one slot cancel out.
        cycle(1, 8'h40, 0, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h40, 1, 0, 0, 8'h0, 0, 0, 0);
        check("simul_same_slot", 32'(obs_aw_slot), 32'd0);
        cycle(0, 8'h0, 1, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h41, 0, 0, 0, 8'h0, 0, 0, 0);
        check("simul_freed_after", 32'(obs_aw_slot), 32'd0);
        drain();
        // Free on slot 1 while slot 2 is allocated.
        cycle(1, 8'h50, 0, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h51, 0, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h52, 1, 1, 0, 8'h0, 0, 0, 0);
        check("simul_alloc_slot2", 32'(obs_aw_slot), 32'd2);
        cycle(1, 8'h53, 0, 0, 0, 8'h0, 0, 0, 0);
        check("simul_slot1_freed", 32'(obs_aw_slot), 32'd1);
        drain();

        // Reset with writes outstanding.
        cycle(1, 8'h60, 0, 0, 0, 8'h0, 0, 0, 0);
        cycle(1, 8'h61, 0, 0, 0, 8'h0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        m_if.awvalid = 1; m_if.awid = 8'h62; s_if.awready = 1;
        #1;
        check("midrst_awready", 32'(m_if.awready), 32'd0);
        check("midrst_awvalid", 32'(s_if.awvalid), 32'd0);
        model_clear();
        @(negedge clk);
        m_if.awvalid = 0;
        rstn = 1'b1;
        cycle(1, 8'h61, 0, 0, 0, 8'h0, 0, 0, 0);
        check("midrst_first_slot", 32'(obs_aw_slot), 32'd0);
        check("midrst_first_ok", 32'(obs_aw_ok), 32'd1);
        drain();

        // Random traffic over a small ID pool to exercise hits, allocation and stalls.
        for (int n = 0; n < 800; n++) begin
            bit bv;
            bit rv;
            int bs;
            int rs;
            s_awready = ($urandom_range(0, 3) != 0);
            s_arready = ($urandom_range(0, 3) != 0);
            m_bready  = ($urandom_range(0, 3) != 0);
            m_rready  = ($urandom_range(0, 3) != 0);
            bs = $urandom_range(0, SLOTS - 1);
            rs = $urandom_range(0, SLOTS - 1);
            bv = (w_cnt[bs] > 0) && ($urandom_range(0, 2) != 0);
            rv = (r_cnt[rs] > 0) && ($urandom_range(0, 2) != 0);
            cycle($urandom_range(0, 9) < 7, 8'($urandom_range(0, 5)), bv, bs,
                  $urandom_range(0, 9) < 7, 8'($urandom_range(0, 5)), rv, rs,
                  1'($urandom_range(0, 1)));
        end
        s_awready = 1; s_arready = 1; m_bready = 1; m_rready = 1;
        drain();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_id_remap.md
AXI_ID_REMAP -- requirements
Module: axi_id_remap

Interface
REQ-001 SHALL have parameter SLOT_NUM, default 4: number of distinct master IDs that may be in flight per direction; power of two, 2..16.
REQ-002 SHALL have parameter ACTIVE_CNT_WIDTH, default 4: width of each slot's outstanding-transaction counter.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port master, axi_channel.slave, master.ID_WIDTH: upstream side carrying wide IDs, e.g. a crossbar slave port.
REQ-006 SHALL have port slave, axi_channel.master, slave.ID_WIDTH == $clog2(SLOT_NUM): downstream side carrying compacted IDs.
REQ-007 SHALL require equal ADDR_WIDTH and DATA_WIDTH on both channels; any mismatch is an elaboration error.

Function
REQ-008 SHALL keep two independent tables, write (AW/B) and read (AR/R), each of SLOT_NUM entries {valid, orig_id[master.ID_WIDTH], cnt[ACTIVE_CNT_WIDTH]}.
REQ-009 SHALL, on master AW valid, select a slot: a valid entry whose orig_id == awid and cnt < 2^ACTIVE_CNT_WIDTH-1 (hit); otherwise the lowest-index invalid entry (alloc); otherwise none (stall).
REQ-010 SHALL, if a valid entry matches awid but its cnt is saturated, stall and not allocate a second slot for that ID, preserving same-ID response ordering.
REQ-011 SHALL drive slave.awvalid = master.awvalid & slot_found and master.awready = slave.awready & slot_found; slave.awid = slot index; all other AW fields pass through unchanged, combinationally.
REQ-012 SHALL, on an AW handshake, set the selected entry valid, write orig_id, and increment cnt by 1.
REQ-013 SHALL pass the W channel through unmodified, with zero latency.
REQ-014 SHALL forward B combinationally: master.bid = write_table[slave.bid].orig_id; bvalid, bready and bresp pass through.
REQ-015 SHALL, on a B handshake, decrement write_table[slave.bid].cnt; when it reaches 0, clear valid in the same edge.
REQ-016 SHALL apply REQ-009..REQ-012 identically to AR against the read table, with arid and slot index in place of awid.
REQ-017 SHALL forward R combinationally: master.rid = read_table[slave.rid].orig_id; data, resp, last, valid and ready pass through.
REQ-018 SHALL decrement the read-table cnt only on an R handshake with rlast = 1.
REQ-019 SHALL, when increment and decrement hit the same slot on one edge, leave cnt unchanged and valid set.
REQ-020 SHALL evaluate slot selection on the table state before the current edge; a slot freed on edge N is allocatable from cycle N+1.
REQ-021 SHALL not assert the AW/AR valid outputs combinationally from a response handshake in the same cycle, so no ready-to-valid loop exists through the tables.
REQ-022 SHALL treat a response whose ID indexes an invalid slot as a protocol error: data passes through, cnt stays 0 (no underflow), and a simulation assertion fires.
REQ-023 SHALL hold address-phase throughput at one handshake per cycle per direction while a slot is available.

Reset
REQ-024 SHALL, while rstn = 0, asynchronously clear every valid bit and every cnt in both tables.
REQ-025 SHALL, while rstn = 0, drive slave.awvalid, slave.arvalid, master.awready and master.arready to 0; the W/B/R pass-through signals follow their sources.
REQ-026 SHALL, on reset deassertion, accept a request on the first cycle after; in-flight transactions at reset are dropped, and the environment resets both sides together.

Verification
REQ-027 SHALL cover single write: AW id 0x2A -> slave awid 0, slot0 cnt 1; B bid 0 -> master bid 0x2A, slot0 freed next cycle.
REQ-028 SHALL cover ID reuse: 3 ARs with id 0x5 then R bursts of len 2 each -> all arid 0, cnt 3,2,1,0 only on rlast beats.
REQ-029 SHALL cover table full: SLOT_NUM=4, ARs ids 1,2,3,4 outstanding, AR id 5 -> arready 0 until an R-last frees a slot, then id 5 takes the freed index.
REQ-030 SHALL cover saturation: ACTIVE_CNT_WIDTH=2, 3 AWs id 7 outstanding, 4th AW id 7 -> stalls with free slots present; resumes after one B.
REQ-031 SHALL cover simultaneous events: AW and B on the same slot in one cycle -> cnt unchanged; B for slot 1 with AW allocating slot 2 -> both updates apply.
REQ-032 SHALL cover mid-operation reset: rstn low with 2 writes outstanding -> tables cleared, awready 0, and after release the first AW gets slot 0.
